// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state encoding and constants for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int PC_STEP = 4;
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with load, hold and flush controls
module if_id_register #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    // load beats flush; flush only drops valid, neither asserted means hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, imem busywait handshake, redirect/drain FSM and IF/ID feed; MISALIGN_TRAP_EN enables misaligned-target traps
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INST_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic                  imem_read,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [INST_WIDTH-1:0] imem_readdata,
    input  logic                  instruction_mem_busywait,
    input  logic                  data_mem_busywait,
    input  logic                  jump_branch_signal,
    input  logic [ADDR_WIDTH-1:0] jump_branch_pc,
    output logic                  if_id_valid,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
    output logic [INST_WIDTH-1:0] if_id_instruction
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                  if_id_misaligned
`endif
);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);
`ifdef MISALIGN_TRAP_EN
    localparam int W = 2 * ADDR_WIDTH + INST_WIDTH + 1;
`else
    localparam int W = 2 * ADDR_WIDTH + INST_WIDTH;
`endif
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pend_q, pend_d, target, entry_pc;
    logic [INST_WIDTH-1:0] entry_instr;
    logic [W-1:0]          entry, entry_q;
    logic                  stall, redirect, mis, park, load, flush;
    assign stall        = data_mem_busywait;
    assign redirect     = jump_branch_signal & ~stall;
    assign imem_read    = state_q != IDLE;
    assign imem_address = pc_q;
    assign entry_pc     = mis ? jump_branch_pc : pc_q;
    assign entry_instr  = mis ? INST_WIDTH'(NOP_INSTR) : imem_readdata;
`ifdef MISALIGN_TRAP_EN
    logic parked_q;
    assign target = jump_branch_pc;
    assign mis    = redirect & |jump_branch_pc[1:0];
    assign park   = parked_q & ~redirect;
    // a trap parks the unit in IDLE until an aligned redirect or reset releases it
    always_ff @(posedge CLK) begin
        if (RESET) parked_q <= 1'b0;
        else if (mis) parked_q <= 1'b1;
        else if (redirect) parked_q <= 1'b0;
    end
    assign entry = {mis, entry_instr, entry_pc + STEP, entry_pc};
    assign {if_id_misaligned, if_id_instruction, if_id_pc_plus4, if_id_pc} = entry_q;
`else
    assign target = jump_branch_pc & ~ADDR_WIDTH'(3);
    assign mis    = 1'b0;
    assign park   = 1'b0;
    assign entry  = {entry_instr, entry_pc + STEP, entry_pc};
    assign {if_id_instruction, if_id_pc_plus4, if_id_pc} = entry_q;
`endif
    // next state, next PC and IF/ID control; a stall freezes all of it
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        load    = 1'b0;
        flush   = ~stall;
        if (mis) begin
            load    = 1'b1;
            pc_d    = jump_branch_pc;
            state_d = IDLE;
        end else if (!stall) begin
            case (state_q)
                IDLE: begin
                    pc_d    = redirect ? target : pc_q;
                    state_d = park ? IDLE : FETCH;
                end
                FETCH: begin
                    load    = ~redirect & ~instruction_mem_busywait;
                    pc_d    = (redirect & ~instruction_mem_busywait) ? target : load ? pc_q + STEP : pc_q;
                    pend_d  = (redirect & instruction_mem_busywait) ? target : pend_q;
                    state_d = (redirect & instruction_mem_busywait) ? DRAIN : FETCH;
                end
                default: begin
                    pend_d  = redirect ? target : pend_q;
                    pc_d    = instruction_mem_busywait ? pc_q : pend_d;
                    state_d = instruction_mem_busywait ? DRAIN : FETCH;
                end
            endcase
        end
    end
    // state, PC and pending redirect target registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end
    if_id_register #(.W(W)) u_if_id (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .load_i  (load),
        .flush_i (flush),
        .data_i  (entry),
        .valid_o (if_id_valid),
        .data_o  (entry_q)
    );
endmodule
